apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
// - Round-robin arbiter sharing one APB master internal port (transfer/ready/write/addr/wdata/rdata) among N_REQ requesters (CPU, DMA, debug).
// - Sequences one transaction at a time: grant, issue, wait for ready, capture rdata, return response to the owner.
// - Sits between requester logic and the APB master; shares PCLK/PRESET with it.
// PARAMETERS
// - N_REQ   2   number of requesters (2..8)
// - IDX_W   $clog2(N_REQ) (min 1)   requester index width; derived, not overridden
// PORTS
// - PCLK         in   1         APB clock
// - PRESET       in   1         asynchronous, active-high reset
// - req_valid    in   N_REQ     request pending, per requester
// - req_write    in   N_REQ     1=write, 0=read, per requester
// - req_addr     in   N_REQ*32  addresses; requester i at [32*i+:32]
// - req_wdata    in   N_REQ*32  write data; requester i at [32*i+:32]
// - req_lock     in   N_REQ     bus lock request; only with APB_ARB_LOCK_EN
// - req_grant    out  N_REQ     one-hot 1-cycle pulse: request accepted
// - resp_valid   out  N_REQ     one-hot 1-cycle pulse: transfer complete
// - resp_rdata   out  32        read data, valid with resp_valid; 0 for writes
// - busy         out  1         high in every state except IDLE
// - m_transfer   out  1         to master transfer
// - m_write      out  1         to master write
// - m_addr       out  32        to master addr
// - m_wdata      out  32        to master wdata
// - m_ready      in   1         from master ready
// - m_rdata      in   32        from master rdata
// BEHAVIOUR
// - Reset: state=IDLE, rr pointer=N_REQ-1 (req0 wins first); all outputs 0; latched addr/wdata/write/owner cleared.
// - FSM:
//   - IDLE: if any req_valid, pick winner, latch its write/addr/wdata and index -> ISSUE. Else stay.
//   - ISSUE: m_transfer=1, req_grant[owner]=1 -> SETUP.
//   - SETUP: master in SETUP; m_ready ignored -> WAIT.
//   - WAIT: sample m_ready; when 1, capture m_rdata (0 if write) -> RESP.
//   - RESP: resp_valid[owner]=1, resp_rdata=captured; rr pointer=owner -> IDLE.
// - m_write/m_addr/m_wdata: driven from latched registers in all states; stable ISSUE..RESP.
// - m_transfer is high only in ISSUE; exactly one pulse per transaction.
// - Latency: grant 1 cycle after request seen in IDLE; resp_valid 3+W cycles after grant (W = WAIT cycles, >=1). Minimum 5 cycles per transaction.
// - Requester protocol: hold req_valid and fields stable until req_grant. May drop or change them afterwards. May re-request immediately after resp_valid.
// - Round-robin: search starts at (pointer+1) mod N_REQ and wraps. A requester re-requesting yields to any other pending requester.
// - Simultaneous requests: lowest index after the pointer wins. Losers keep req_valid and are served in later rounds without starvation.
// - req_valid dropping before grant while in IDLE: not considered. Once latched in IDLE, the transaction completes regardless.
// - m_ready outside WAIT has no effect.
// - PRESET mid-transaction: immediate return to IDLE with no resp_valid; the master is reset by the same signal.
// CONFIGURATION
// - `APB_ARB_LOCK_EN defined:
//   - req_lock port exists.
//   - If req_lock[owner]=1 in RESP, the lock is held for that owner.
//   - While locked, IDLE grants only the owner; other requesters wait, even if the owner is idle.
//   - The lock is released when req_lock[owner]=0 in IDLE or RESP; normal RR resumes with pointer=owner.
// - `APB_ARB_LOCK_EN undefined: req_lock port absent; pure round-robin.
// STRUCTURE
// - Package apb_arb_pkg:
//   - apb_arb_state_e {IDLE, ISSUE, SETUP, WAIT, RESP}
//   - localparam ADDR_W=32, DATA_W=32
// - Sub-module apb_rr_picker (combinational).
//   - Inputs: req mask, pointer.
//   - Outputs: one-hot grant, winner index, any.
//   - Instantiated once.
// - FSM, latches and response registers live in this module.
// TESTING
// - Single read: req0 read 0x1000_0004, slave returns 0xDEAD_BEEF with zero wait.
//   - Expect grant0 at t+1, m_transfer 1 cycle, resp_valid0 with 0xDEAD_BEEF 4 cycles after grant.
// - Single write: req1 write 0x1000_1000 with data 0x1234_5678.
//   - Expect m_write=1 and m_addr/m_wdata held through RESP.
//   - Expect resp_valid1 with resp_rdata=0.
// - Contention: req0 and req1 held continuously from reset.
//   - Expect grant order 0,1,0,1; one m_transfer per grant; no overlap.
// - Wait states: slave ready after 3 ACCESS cycles.
//   - Expect resp_valid 6 cycles after grant; busy high throughout.
// - Reset during WAIT: assert PRESET.
//   - Expect all outputs 0 and state IDLE; no resp_valid.
//   - The next request is granted normally.
// - Lock (APB_ARB_LOCK_EN): req0 issues 3 locked requests while req1 is pending.
//   - Expect req0 served 3 times, then req1 once req_lock0 drops.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types and widths for the APB master round-robin arbiter.
package apb_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        SETUP,
        WAIT,
        RESP
    } apb_arb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } apb_arb_req_t;

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: scans from ptr+1 upward, wrapping, and
// returns the first set bit of req as one-hot grant plus its index.
module apb_rr_picker #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found;
    int   c;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        any   = |req;
        // ptr itself is checked last, so the previous owner yields to everyone else
        for (int k = 1; k <= N_REQ; k++) begin
            c = (int'(ptr) + k) % N_REQ;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port among N_REQ requesters.
// Optional bus lock feature enabled by defining APB_ARB_LOCK_EN.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_write,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
`ifdef APB_ARB_LOCK_EN
    input  logic [N_REQ-1:0]        req_lock,
`endif
    output logic [N_REQ-1:0]        req_grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]       resp_rdata,
    output logic                    busy,
    output logic                    m_transfer,
    output logic                    m_write,
    output logic [ADDR_W-1:0]       m_addr,
    output logic [DATA_W-1:0]       m_wdata,
    input  logic                    m_ready,
    input  logic [DATA_W-1:0]       m_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    apb_arb_state_e           state, state_nx;
    logic [IDX_W-1:0]         ptr, owner;
    apb_arb_req_t             lat;
    logic [DATA_W-1:0]        rdata_cap;
    apb_arb_req_t [N_REQ-1:0] req_f;
    apb_arb_req_t             pick_req;
    logic [N_REQ-1:0]         pick_mask, pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_any;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign req_f[i] = '{write: req_write[i],
                            addr:  req_addr[ADDR_W*i +: ADDR_W],
                            wdata: req_wdata[DATA_W*i +: DATA_W]};
    end

`ifdef APB_ARB_LOCK_EN
    logic locked;
    logic lock_hold;

    // Lock is dropped in IDLE as soon as the owner lowers req_lock
    assign lock_hold = locked && req_lock[owner];
    assign pick_mask = lock_hold ? (req_valid & (N_REQ'(1) << owner)) : req_valid;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            locked <= 1'b0;
        end else if (state == RESP) begin
            locked <= req_lock[owner];
        end else if (state == IDLE && !lock_hold) begin
            locked <= 1'b0;
        end
    end
`else
    assign pick_mask = req_valid;
`endif

    apb_rr_picker #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_picker (
        .req  (pick_mask),
        .ptr  (ptr),
        .grant(pick_grant),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_comb begin
        pick_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) pick_req = req_f[i];
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_any) state_nx = ISSUE;
            ISSUE:   state_nx = SETUP;
            SETUP:   state_nx = WAIT;
            WAIT:    if (m_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_transfer = (state == ISSUE);
        req_grant  = (state == ISSUE) ? (N_REQ'(1) << owner) : '0;
        busy       = (state != IDLE);
        m_write    = lat.write;
        m_addr     = lat.addr;
        m_wdata    = lat.wdata;
    end

    // Response is registered out of RESP, so it lands on the cycle the FSM is back in IDLE
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            ptr        <= IDX_W'(N_REQ - 1);
            owner      <= '0;
            lat        <= '0;
            rdata_cap  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nx;
            resp_valid <= '0;
            resp_rdata <= '0;
            unique case (state)
                IDLE: if (pick_any) begin
                    owner <= pick_idx;
                    lat   <= pick_req;
                end
                WAIT: if (m_ready) rdata_cap <= lat.write ? '0 : m_rdata;
                RESP: begin
                    ptr        <= owner;
                    resp_valid <= N_REQ'(1) << owner;
                    resp_rdata <= rdata_cap;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_apb_master_arbiter;

    localparam int N = 3;

    logic            PCLK = 1'b0;
    logic            PRESET;
    logic [N-1:0]    req_valid, req_write, req_lock;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]    req_grant, resp_valid;
    logic [31:0]     resp_rdata, m_addr, m_wdata, m_rdata;
    logic            busy, m_transfer, m_write, m_ready;

    int ntests = 0;
    int nfail  = 0;
    int ptr_m;
    bit locked_m;
    int lock_own_m;

    always #5 PCLK = ~PCLK;

    apb_master_arbiter #(.N_REQ(N)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef APB_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_grant (req_grant),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .busy      (busy),
        .m_transfer(m_transfer),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_rdata   (m_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: lock first, otherwise first pending requester after the pointer
    function automatic int model_winner();
        if (locked_m && req_lock[lock_own_m]) return req_valid[lock_own_m] ? lock_own_m : -1;
        for (int k = 1; k <= N; k++) begin
            int c = (ptr_m + k) % N;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = wr;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
    endtask

    task automatic model_reset();
        ptr_m    = N - 1;
        locked_m = 1'b0;
        lock_own_m = 0;
    endtask

    // Runs one transaction starting from an IDLE cycle; acts as the APB master with W access cycles
    task automatic do_txn(input int W, input logic [31:0] rd, input bit drop,
                          input logic [N-1:0] lock_after, output int dut_w);
        int exp_w, lat;
        logic ewr;
        logic [31:0] ea, ed;
        dut_w = -1;
        if (locked_m && !req_lock[lock_own_m]) locked_m = 1'b0;
        exp_w = model_winner();
        ntests++;
        assert (exp_w >= 0) else begin
            nfail++;
            $error("FAIL no_pending: got %0d expected a pending requester", exp_w);
            return;
        end
        ewr = req_write[exp_w];
        ea  = req_addr[32*exp_w +: 32];
        ed  = req_wdata[32*exp_w +: 32];
        lat = 0;
        do begin
            @(posedge PCLK); #1;
            lat++;
        end while (req_grant == '0 && lat < 8);
        for (int i = 0; i < N; i++) if (req_grant[i]) dut_w = i;
        chk("grant_latency", lat, 1);
        chk("grant_onehot", req_grant, N'(1) << exp_w);
        chk("issue_transfer", m_transfer, 1'b1);
        chk("issue_busy", busy, 1'b1);
        chk("issue_write", m_write, ewr);
        chk("issue_addr", m_addr, ea);
        chk("issue_wdata", m_wdata, ed);
        if (drop) req_valid[exp_w] = 1'b0;
        req_lock = lock_after;
        m_ready  = $urandom_range(0, 1);
        m_rdata  = $urandom;
        @(posedge PCLK); #1;
        chk("setup_transfer", m_transfer, 1'b0);
        chk("setup_grant", req_grant, '0);
        m_ready = $urandom_range(0, 1);
        m_rdata = $urandom;
        for (int k = 1; k <= W; k++) begin
            @(posedge PCLK); #1;
            chk("wait_busy", busy, 1'b1);
            chk("wait_transfer", m_transfer, 1'b0);
            chk("wait_resp", resp_valid, '0);
            chk("wait_addr", m_addr, ea);
            chk("wait_wdata", m_wdata, ed);
            chk("wait_write", m_write, ewr);
            m_ready = (k == W);
            m_rdata = (k == W) ? rd : $urandom;
        end
        @(posedge PCLK); #1;
        chk("resp_state_busy", busy, 1'b1);
        chk("resp_early", resp_valid, '0);
        chk("resp_state_addr", m_addr, ea);
        chk("resp_state_wdata", m_wdata, ed);
        locked_m   = req_lock[exp_w];
        lock_own_m = exp_w;
        m_ready    = $urandom_range(0, 1);
        m_rdata    = $urandom;
        @(posedge PCLK); #1;
        chk("resp_valid", resp_valid, N'(1) << exp_w);
        chk("resp_rdata", resp_rdata, ewr ? 32'h0 : rd);
        chk("resp_busy", busy, 1'b0);
        m_ready = 1'b0;
        ptr_m   = exp_w;
    endtask

    task automatic apply_reset();
        PRESET    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        m_ready   = 1'b0;
        m_rdata   = '0;
        model_reset();
        @(posedge PCLK); @(posedge PCLK); #1;
        PRESET = 1'b0;
    endtask

    initial begin
        int w, w1, w2, w3, w4;
        apply_reset();

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_transfer", m_transfer, 1'b0);
        chk("rst_grant", req_grant, '0);
        chk("rst_resp", resp_valid, '0);
        chk("rst_addr", m_addr, '0);
        chk("rst_rdata", resp_rdata, '0);
        @(posedge PCLK); #1;
        chk("idle_grant", req_grant, '0);
        chk("idle_busy", busy, 1'b0);

        // Single read, single write, wait states
        set_req(0, 1'b0, 32'h1000_0004, 32'h0);
        do_txn(1, 32'hDEAD_BEEF, 1'b1, '0, w);
        set_req(1, 1'b1, 32'h1000_1000, 32'h1234_5678);
        do_txn(1, 32'hFFFF_FFFF, 1'b1, '0, w);
        set_req(2, 1'b0, 32'h2000_0010, 32'h0);
        do_txn(3, 32'hCAFE_F00D, 1'b1, '0, w);

        // Contention held from reset: 0,1,0,1
        apply_reset();
        set_req(0, 1'b0, 32'h0000_0100, 32'h0);
        set_req(1, 1'b1, 32'h0000_0200, 32'hA5A5_A5A5);
        do_txn(1, 32'h1111_1111, 1'b0, '0, w1);
        do_txn(2, 32'h2222_2222, 1'b0, '0, w2);
        do_txn(1, 32'h3333_3333, 1'b0, '0, w3);
        do_txn(1, 32'h4444_4444, 1'b0, '0, w4);
        chk("contend_order", {8'(w1), 8'(w2), 8'(w3), 8'(w4)}, 32'h0001_0001);
        req_valid = '0;
        @(posedge PCLK); #1;

        // Reset asserted while in WAIT
        set_req(0, 1'b0, 32'h3000_0000, 32'h0);
        @(posedge PCLK); #1;
        chk("rstwait_grant", req_grant, 3'b001);
        req_valid = '0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        chk("rstwait_busy", busy, 1'b0);
        chk("rstwait_transfer", m_transfer, 1'b0);
        chk("rstwait_addr", m_addr, '0);
        chk("rstwait_grant0", req_grant, '0);
        m_ready = 1'b1;
        @(posedge PCLK); @(posedge PCLK); #1;
        chk("rstwait_noresp", resp_valid, '0);
        PRESET  = 1'b0;
        m_ready = 1'b0;
        model_reset();
        set_req(0, 1'b0, 32'h3000_0004, 32'h0);
        set_req(1, 1'b1, 32'h3000_0008, 32'h5555_AAAA);
        do_txn(1, 32'h7777_0000, 1'b1, '0, w1);
        chk("post_rst_first", w1, 0);
        do_txn(1, 32'h7777_0001, 1'b1, '0, w);

`ifdef APB_ARB_LOCK_EN
        // req0 locks the bus for three transfers while req1 waits
        set_req(1, 1'b0, 32'h4000_1000, 32'h0);
        set_req(0, 1'b1, 32'h4000_0000, 32'h0BAD_F00D);
        req_lock = 3'b001;
        do_txn(1, 32'h0, 1'b0, 3'b001, w1);
        do_txn(2, 32'h0, 1'b0, 3'b001, w2);
        do_txn(1, 32'h0, 1'b1, 3'b000, w3);
        do_txn(1, 32'h4242_4242, 1'b1, 3'b000, w4);
        chk("lock_order", {8'(w1), 8'(w2), 8'(w3), 8'(w4)}, 32'h0000_0001);
`endif

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
            if (req_valid == '0) set_req($urandom_range(0, N - 1), 1'b0, $urandom, $urandom);
            do_txn($urandom_range(1, 4), $urandom, ($urandom_range(0, 3) != 0), req_lock, w);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
